// File: rtl/apb_mgr_arbiter_pkg.sv
// Shared types and defaults for the APB manager arbiter.
// State encoding for the arbiter FSM and the default watchdog limit.
package apb_mgr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_arb_state_e;

    localparam int unsigned ApbTimeoutDefault = 255;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker.
// Ports: req_i (requests), last_i (previous winner),
//        gnt_idx_o (first requester after last_i), gnt_valid_o.
module apb_rr_pick #(
    parameter int unsigned NrMgr = 2
) (
    input  logic [NrMgr-1:0]         req_i,
    input  logic [$clog2(NrMgr)-1:0] last_i,
    output logic [$clog2(NrMgr)-1:0] gnt_idx_o,
    output logic                     gnt_valid_o
);

    localparam int unsigned IdxW = $clog2(NrMgr);

    int unsigned j;

    // Walk offsets from farthest to nearest so the nearest
    // requester after last_i is the final (winning) assignment.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        j           = 0;
        for (int unsigned k = NrMgr; k >= 1; k--) begin
            j = (32'(last_i) + k) % NrMgr;
            if (req_i[IdxW'(j)]) begin
                gnt_idx_o   = IdxW'(j);
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mgr_arbiter.sv
// Round-robin arbiter sharing one APB bus between NrMgr managers,
// with registered downstream request and a stall watchdog.
// Ports: clk_i, rst_ni; m_* manager side (per-manager vectors);
//        s_* downstream APB; timeout_o pulses on watchdog abort.
module apb_mgr_arbiter
    import apb_mgr_arbiter_pkg::*;
#(
    parameter int unsigned NrMgr         = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = ApbTimeoutDefault
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrMgr-1:0]                    m_psel_i,
    input  logic [NrMgr-1:0]                    m_penable_i,
    input  logic [NrMgr-1:0]                    m_pwrite_i,
    input  logic [NrMgr-1:0][AddrWidth-1:0]     m_paddr_i,
    input  logic [NrMgr-1:0][DataWidth-1:0]     m_pwdata_i,
    output logic [NrMgr-1:0][DataWidth-1:0]     m_prdata_o,
    output logic [NrMgr-1:0]                    m_pready_o,
    output logic [NrMgr-1:0]                    m_pslverr_o,
    output logic                                s_psel_o,
    output logic                                s_penable_o,
    output logic                                s_pwrite_o,
    output logic [AddrWidth-1:0]                s_paddr_o,
    output logic [DataWidth-1:0]                s_pwdata_o,
    input  logic [DataWidth-1:0]                s_prdata_i,
    input  logic                                s_pready_i,
    input  logic                                s_pslverr_i,
    output logic                                timeout_o
);

    localparam int unsigned IdxW = $clog2(NrMgr);
    localparam int unsigned TmoW =
        (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    localparam logic [TmoW-1:0] TmoMax  = '1;

    apb_arb_state_e       state_q, state_d;
    logic [IdxW-1:0]      last_q, last_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic                 alive_q, alive_d;
    logic                 tpulse_q, tpulse_d;

    logic [IdxW-1:0]      gnt_idx;
    logic                 gnt_valid;
    logic                 resp;

    apb_rr_pick #(
        .NrMgr (NrMgr)
    ) u_pick (
        .req_i       (m_psel_i),
        .last_i      (last_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // last_q doubles as the current grant once a transfer starts.
    // alive_q tracks whether the granted manager still holds psel;
    // if it drops, the response is swallowed.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        alive_d  = alive_q;
        tpulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    last_d  = gnt_idx;
                    addr_d  = m_paddr_i[gnt_idx];
                    wdata_d = m_pwdata_i[gnt_idx];
                    write_d = m_pwrite_i[gnt_idx];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    alive_d = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                alive_d = alive_q & m_psel_i[last_q];
                state_d = ACCESS;
            end
            ACCESS: begin
                alive_d = alive_q & m_psel_i[last_q];
                if (s_pready_i) begin
                    rdata_d = s_prdata_i;
                    err_d   = s_pslverr_i;
                    state_d = RESP;
                end else begin
                    if (tmo_q != TmoMax) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (TimeoutCycles != 0 && tmo_q == TmoLast) begin
                        err_d    = 1'b1;
                        rdata_d  = '0;
                        tpulse_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            last_q   <= IdxW'(NrMgr - 1);
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            alive_q  <= 1'b0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            alive_q  <= alive_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign s_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign s_penable_o = (state_q == ACCESS);
    assign s_pwrite_o  = write_q;
    assign s_paddr_o   = addr_q;
    assign s_pwdata_o  = wdata_q;
    assign timeout_o   = tpulse_q;

    assign resp = (state_q == RESP) && alive_q;

    always_comb begin
        m_prdata_o  = '0;
        m_pready_o  = '0;
        m_pslverr_o = '0;
        if (resp) begin
            m_prdata_o[last_q]  = rdata_q;
            m_pready_o[last_q]  = 1'b1;
            m_pslverr_o[last_q] = err_q;
        end
    end

endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// Directed testbench for apb_mgr_arbiter (2 managers, watchdog of 4).
// Linear stimulus with hand-computed expectations.
module tb_apb_mgr_arbiter;

    logic              clk_i;
    logic              rst_ni;
    logic [1:0]        m_psel_i;
    logic [1:0]        m_penable_i;
    logic [1:0]        m_pwrite_i;
    logic [1:0][31:0]  m_paddr_i;
    logic [1:0][31:0]  m_pwdata_i;
    logic [1:0][31:0]  m_prdata_o;
    logic [1:0]        m_pready_o;
    logic [1:0]        m_pslverr_o;
    logic              s_psel_o;
    logic              s_penable_o;
    logic              s_pwrite_o;
    logic [31:0]       s_paddr_o;
    logic [31:0]       s_pwdata_o;
    logic [31:0]       s_prdata_i;
    logic              s_pready_i;
    logic              s_pslverr_i;
    logic              timeout_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    apb_mgr_arbiter #(
        .NrMgr         (2),
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m_psel_i    (m_psel_i),
        .m_penable_i (m_penable_i),
        .m_pwrite_i  (m_pwrite_i),
        .m_paddr_i   (m_paddr_i),
        .m_pwdata_i  (m_pwdata_i),
        .m_prdata_o  (m_prdata_o),
        .m_pready_o  (m_pready_o),
        .m_pslverr_o (m_pslverr_o),
        .s_psel_o    (s_psel_o),
        .s_penable_o (s_penable_o),
        .s_pwrite_o  (s_pwrite_o),
        .s_paddr_o   (s_paddr_o),
        .s_pwdata_o  (s_pwdata_o),
        .s_prdata_i  (s_prdata_i),
        .s_pready_i  (s_pready_i),
        .s_pslverr_i (s_pslverr_i),
        .timeout_o   (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni      = 1'b0;
        m_psel_i    = '0;
        m_penable_i = '0;
        m_pwrite_i  = '0;
        m_paddr_i   = '0;
        m_pwdata_i  = '0;
        s_prdata_i  = '0;
        s_pready_i  = 1'b0;
        s_pslverr_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_psel", 64'(s_psel_o), 64'd0);
        chk("rst_penable", 64'(s_penable_o), 64'd0);
        chk("rst_paddr", 64'(s_paddr_o), 64'd0);
        chk("rst_pwdata", 64'(s_pwdata_o), 64'd0);
        chk("rst_pready", 64'(m_pready_o), 64'd0);
        chk("rst_pslverr", 64'(m_pslverr_o), 64'd0);
        chk("rst_prdata", 64'(m_prdata_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Single read, zero-wait: mgr0 reads 0x3000
        m_psel_i     = 2'b01;
        m_paddr_i[0] = 32'h0000_3000;
        m_paddr_i[1] = 32'h0000_2004;
        s_pready_i   = 1'b1;
        s_prdata_i   = 32'hDEAD_BEEF;
        tick();
        chk("rd_setup_psel", 64'(s_psel_o), 64'd1);
        chk("rd_setup_pen", 64'(s_penable_o), 64'd0);
        chk("rd_setup_addr", 64'(s_paddr_o), 64'h3000);
        chk("rd_setup_write", 64'(s_pwrite_o), 64'd0);
        m_penable_i = 2'b01;
        tick();
        chk("rd_access_pen", 64'(s_penable_o), 64'd1);
        chk("rd_access_rdy", 64'(m_pready_o), 64'd0);
        tick();
        chk("rd_resp_rdy", 64'(m_pready_o), 64'b01);
        chk("rd_resp_data0", 64'(m_prdata_o[0]), 64'hDEAD_BEEF);
        chk("rd_resp_data1", 64'(m_prdata_o[1]), 64'd0);
        chk("rd_resp_err", 64'(m_pslverr_o), 64'd0);
        chk("rd_resp_psel", 64'(s_psel_o), 64'd0);
        m_psel_i    = 2'b00;
        m_penable_i = 2'b00;
        tick();
        chk("rd_idle_rdy", 64'(m_pready_o), 64'd0);
        chk("rd_idle_psel", 64'(s_psel_o), 64'd0);

        // Simultaneous requests after reset: 0,1,0,1 ...
        do_reset();
        m_paddr_i[0] = 32'h0000_1000;
        m_paddr_i[1] = 32'h0000_2000;
        m_psel_i     = 2'b11;
        s_pready_i   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 8 && !(s_psel_o && !s_penable_o); c++)
                tick();
            chk("rr_setup_addr", 64'(s_paddr_o),
                (k % 2 == 0) ? 64'h1000 : 64'h2000);
            for (int c = 0; c < 8 && m_pready_o == 2'b00; c++)
                tick();
            chk("rr_grant", 64'(m_pready_o),
                (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
        end
        m_psel_i   = 2'b00;
        s_pready_i = 1'b0;
        tick();
        tick();
        chk("rr_done_idle", 64'(s_psel_o), 64'd0);

        // Wait states and error: mgr1 writes 0x55 to 0x2004
        m_psel_i      = 2'b10;
        m_pwrite_i    = 2'b10;
        m_paddr_i[1]  = 32'h0000_2004;
        m_pwdata_i[1] = 32'h0000_0055;
        s_prdata_i    = 32'h0000_1234;
        tick();
        chk("ws_setup_addr", 64'(s_paddr_o), 64'h2004);
        chk("ws_setup_write", 64'(s_pwrite_o), 64'd1);
        chk("ws_setup_wdata", 64'(s_pwdata_o), 64'h55);
        m_pwdata_i[1] = 32'h0000_00AA;
        m_paddr_i[1]  = 32'h0000_9999;
        m_pwrite_i    = 2'b00;
        m_penable_i   = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ws_wait_pen", 64'(s_penable_o), 64'd1);
            chk("ws_wait_wdata", 64'(s_pwdata_o), 64'h55);
            chk("ws_wait_addr", 64'(s_paddr_o), 64'h2004);
            chk("ws_wait_rdy", 64'(m_pready_o), 64'd0);
        end
        tick();
        chk("ws_last_wdata", 64'(s_pwdata_o), 64'h55);
        chk("ws_last_write", 64'(s_pwrite_o), 64'd1);
        s_pready_i  = 1'b1;
        s_pslverr_i = 1'b1;
        tick();
        chk("ws_resp_rdy", 64'(m_pready_o), 64'b10);
        chk("ws_resp_err", 64'(m_pslverr_o), 64'b10);
        chk("ws_resp_data", 64'(m_prdata_o[1]), 64'h1234);
        chk("ws_ready_wins", 64'(timeout_o), 64'd0);
        m_psel_i     = 2'b00;
        m_penable_i  = 2'b00;
        s_pready_i   = 1'b0;
        s_pslverr_i  = 1'b0;
        m_paddr_i[1] = 32'h0000_2004;
        tick();

        // Watchdog: peripheral never ready, limit of 4 ACCESS cycles
        m_psel_i     = 2'b01;
        m_paddr_i[0] = 32'h0000_3000;
        s_prdata_i   = 32'hFFFF_FFFF;
        tick();
        chk("wd_setup_addr", 64'(s_paddr_o), 64'h3000);
        m_penable_i = 2'b01;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("wd_access_pen", 64'(s_penable_o), 64'd1);
            chk("wd_no_pulse", 64'(timeout_o), 64'd0);
        end
        tick();
        chk("wd_timeout", 64'(timeout_o), 64'd1);
        chk("wd_rdy", 64'(m_pready_o), 64'b01);
        chk("wd_err", 64'(m_pslverr_o), 64'b01);
        chk("wd_data", 64'(m_prdata_o[0]), 64'd0);
        chk("wd_psel_off", 64'(s_psel_o), 64'd0);
        m_psel_i    = 2'b00;
        m_penable_i = 2'b00;
        tick();
        chk("wd_pulse_once", 64'(timeout_o), 64'd0);
        m_psel_i   = 2'b01;
        s_pready_i = 1'b1;
        s_prdata_i = 32'h0000_CAFE;
        tick();
        tick();
        tick();
        chk("wd_next_rdy", 64'(m_pready_o), 64'b01);
        chk("wd_next_err", 64'(m_pslverr_o), 64'd0);
        chk("wd_next_data", 64'(m_prdata_o[0]), 64'hCAFE);
        chk("wd_next_tmo", 64'(timeout_o), 64'd0);
        m_psel_i   = 2'b00;
        s_pready_i = 1'b0;
        tick();

        // Reset mid-transfer
        m_psel_i = 2'b10;
        tick();
        tick();
        chk("mr_in_access", 64'(s_penable_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mr_psel", 64'(s_psel_o), 64'd0);
        chk("mr_penable", 64'(s_penable_o), 64'd0);
        chk("mr_paddr", 64'(s_paddr_o), 64'd0);
        chk("mr_pready", 64'(m_pready_o), 64'd0);
        chk("mr_prdata", 64'(m_prdata_o), 64'd0);
        m_psel_i   = 2'b11;
        s_pready_i = 1'b1;
        s_prdata_i = 32'h0000_0077;
        #1;
        rst_ni = 1'b1;
        tick();
        chk("mr_tie_addr", 64'(s_paddr_o), 64'h3000);
        tick();
        tick();
        chk("mr_tie_rdy", 64'(m_pready_o), 64'b01);

        // Manager 1 abandons its transfer during ACCESS
        m_psel_i   = 2'b10;
        s_pready_i = 1'b0;
        tick();
        tick();
        chk("ab_setup_addr", 64'(s_paddr_o), 64'h2004);
        tick();
        chk("ab_access", 64'(s_penable_o), 64'd1);
        m_psel_i = 2'b00;
        tick();
        chk("ab_still_access", 64'(s_penable_o), 64'd1);
        s_pready_i = 1'b1;
        tick();
        chk("ab_resp_silent", 64'(m_pready_o), 64'd0);
        chk("ab_resp_err", 64'(m_pslverr_o), 64'd0);
        chk("ab_resp_psel", 64'(s_psel_o), 64'd0);
        s_pready_i = 1'b0;
        tick();
        chk("ab_idle_psel", 64'(s_psel_o), 64'd0);
        chk("ab_idle_rdy", 64'(m_pready_o), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
